// File: rtl/bk_sram_arbiter.sv
// Arbitrates one 16-bit async SRAM between the BK CPU bus and the video fetcher.
// Every access is one IDLE grant cycle followed by ACC_CYCLES cycles with the strobes held.
module bk_sram_arbiter #(
    parameter int ACC_CYCLES = 2
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        cpu_rd,
    input  logic        cpu_wt,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_adr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_rdy,
    input  logic        vid_req,
    input  logic [13:0] vid_adr,
    output logic        vid_ack,
    output logic [15:0] vid_data,
    output logic [14:0] sram_a,
    output logic [15:0] sram_d_o,
    output logic        sram_d_oe,
    input  logic [15:0] sram_d_i,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       last_vid, cur_vid, cur_wr;
    logic       cpu_req, cpu_pend;
    logic       grant_cpu, grant_vid, acc_end;

    assign cpu_req  = cpu_rd | cpu_wt;
    assign cpu_pend = cpu_req & ~cpu_rdy;

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // On contention the requester that was not served last wins.
    always_comb begin
        state_nx  = state;
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        acc_end   = 1'b0;
        case (state)
            IDLE: begin
                if (vid_req && (!cpu_pend || !last_vid)) grant_vid = 1'b1;
                else if (cpu_pend)                       grant_cpu = 1'b1;
                if (grant_vid || grant_cpu) state_nx = ACCESS;
            end
            ACCESS: begin
                if (cnt == ACC_LAST) begin
                    acc_end  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            cnt       <= '0;
            last_vid  <= 1'b0;
            cur_vid   <= 1'b0;
            cur_wr    <= 1'b0;
            cpu_rdy   <= 1'b0;
            cpu_din   <= '0;
            vid_ack   <= 1'b0;
            vid_data  <= '0;
            sram_a    <= '0;
            sram_d_o  <= '0;
            sram_d_oe <= 1'b0;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
        end else begin
            vid_ack <= 1'b0;
            if (!cpu_req) cpu_rdy <= 1'b0;

            if (grant_vid) begin
                sram_a    <= {2'b01, vid_adr[12:0]};
                sram_d_o  <= cpu_dout;
                sram_d_oe <= 1'b0;
                sram_oe_n <= 1'b0;
                sram_we_n <= 1'b1;
                sram_ub_n <= 1'b0;
                sram_lb_n <= 1'b0;
                cur_vid   <= 1'b1;
                cur_wr    <= 1'b0;
                last_vid  <= 1'b1;
                cnt       <= 4'd1;
            end else if (grant_cpu) begin
                // A simultaneous rd+wt is a write; byte lane picked by adr[0].
                sram_a    <= cpu_adr[15:1];
                sram_d_o  <= cpu_dout;
                sram_d_oe <= cpu_wt;
                sram_oe_n <= cpu_wt;
                sram_we_n <= 1'b1;
                sram_ub_n <= cpu_wt & cpu_byte & ~cpu_adr[0];
                sram_lb_n <= cpu_wt & cpu_byte & cpu_adr[0];
                cur_vid   <= 1'b0;
                cur_wr    <= cpu_wt;
                last_vid  <= 1'b0;
                cnt       <= 4'd1;
            end else if (acc_end) begin
                sram_d_oe <= 1'b0;
                sram_oe_n <= 1'b1;
                sram_we_n <= 1'b1;
                sram_ub_n <= 1'b1;
                sram_lb_n <= 1'b1;
                if (cur_vid) begin
                    vid_data <= sram_d_i;
                    vid_ack  <= 1'b1;
                end else if (cpu_req) begin
                    cpu_rdy <= 1'b1;
                    if (!cur_wr) cpu_din <= sram_d_i;
                end
            end else if (state == ACCESS) begin
                // Write enable opens one cycle after address/data settle.
                cnt <= cnt + 4'd1;
                if (cur_wr) sram_we_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bk_sram_arbiter.sv
// Randomized scoreboard bench for bk_sram_arbiter against a word-array SRAM reference.
module tb_bk_sram_arbiter;

    localparam int ACC = 2;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wt = 1'b0, cpu_byte = 1'b0;
    logic [15:0] cpu_adr = '0, cpu_dout = '0, cpu_din;
    logic        cpu_rdy;
    logic        vid_req = 1'b0;
    logic [13:0] vid_adr = '0;
    logic        vid_ack;
    logic [15:0] vid_data;
    logic [14:0] sram_a;
    logic [15:0] sram_d_o, sram_d_i;
    logic        sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    bk_sram_arbiter #(.ACC_CYCLES(ACC)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_byte(cpu_byte), .cpu_adr(cpu_adr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack), .vid_data(vid_data),
        .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 m_clock = ~m_clock;

    // Physical SRAM seen by the DUT, and the bench's own notion of its contents.
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    assign sram_d_i = mem[sram_a];

    always @(posedge m_clock) begin
        if (!sram_we_n && sram_d_oe) begin
            if (!sram_ub_n) mem[sram_a][15:8] <= sram_d_o[15:8];
            if (!sram_lb_n) mem[sram_a][7:0]  <= sram_d_o[7:0];
        end
    end

    int cyc = 0;
    always @(posedge m_clock) cyc <= cyc + 1;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
        logic        wr;
        logic        ub_n;
        logic        lb_n;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        vid_q[$];
    int          errors = 0, checks = 0;
    int          rdy_cyc = 0, ack_cyc = 0;
    logic [15:0] exp_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every completion and checks strobe shape.
    initial begin : mon
        exp_t e;
        int   oe_cnt, we_cnt;
        logic prev_rdy, prev_ack, seen_ub, seen_lb;
        oe_cnt = 0; we_cnt = 0; prev_rdy = 0; prev_ack = 0; seen_ub = 1; seen_lb = 1;
        forever begin
            @(negedge m_clock);
            if (p_reset) begin
                oe_cnt = 0; we_cnt = 0;
            end else begin
                if (!sram_oe_n) oe_cnt++;
                if (!sram_we_n) begin
                    we_cnt++;
                    seen_ub = sram_ub_n;
                    seen_lb = sram_lb_n;
                end
                if (vid_ack) begin
                    chk("vid_ack_single", {31'b0, prev_ack}, 0);
                    if (vid_q.size() == 0) chk("vid_unexpected_ack", 1, 0);
                    else begin
                        e = vid_q.pop_front();
                        chk("vid_data", {16'b0, vid_data}, {16'b0, e.d});
                        chk("vid_sram_a", {17'b0, sram_a}, {17'b0, e.a});
                        chk("vid_oe_cycles", oe_cnt, ACC);
                        chk("vid_we_cycles", we_cnt, 0);
                    end
                    ack_cyc = cyc; oe_cnt = 0; we_cnt = 0;
                end
                if (cpu_rdy && !prev_rdy) begin
                    if (cpu_q.size() == 0) chk("cpu_unexpected_rdy", 1, 0);
                    else begin
                        e = cpu_q.pop_front();
                        chk("cpu_din", {16'b0, cpu_din}, {16'b0, e.d});
                        chk("cpu_sram_a", {17'b0, sram_a}, {17'b0, e.a});
                        if (e.wr) begin
                            chk("wr_we_cycles", we_cnt, ACC - 1);
                            chk("wr_oe_cycles", oe_cnt, 0);
                            chk("wr_lanes", {30'b0, seen_ub, seen_lb}, {30'b0, e.ub_n, e.lb_n});
                        end else begin
                            chk("rd_oe_cycles", oe_cnt, ACC);
                            chk("rd_we_cycles", we_cnt, 0);
                        end
                    end
                    rdy_cyc = cyc; oe_cnt = 0; we_cnt = 0;
                end
            end
            prev_rdy = cpu_rdy;
            prev_ack = vid_ack;
        end
    end

    // Called at a negedge; runs one full CPU handshake.
    task automatic cpu_op(input logic rd, input logic wt, input logic byt,
                          input logic [15:0] adr, input logic [15:0] dat, input int hold);
        exp_t e;
        int   n;
        e.a = adr[15:1]; e.wr = wt;
        e.ub_n = wt & byt & ~adr[0];
        e.lb_n = wt & byt & adr[0];
        if (wt) begin
            if (!e.ub_n) ref_mem[e.a][15:8] = dat[15:8];
            if (!e.lb_n) ref_mem[e.a][7:0]  = dat[7:0];
            e.d = exp_din;
        end else begin
            e.d = ref_mem[e.a];
            exp_din = e.d;
        end
        cpu_q.push_back(e);
        cpu_rd = rd; cpu_wt = wt; cpu_byte = byt; cpu_adr = adr; cpu_dout = dat;
        n = 0;
        do begin @(negedge m_clock); n++; end while (!cpu_rdy && n < 30);
        chk("cpu_latency_ok", {31'b0, n <= 2 * (ACC + 1)}, 1);
        cpu_adr = ~adr;
        repeat (hold) begin
            @(negedge m_clock);
            chk("cpu_rdy_hold", {31'b0, cpu_rdy}, 1);
        end
        cpu_rd = 0; cpu_wt = 0;
        @(negedge m_clock);
        chk("cpu_rdy_clear", {31'b0, cpu_rdy}, 0);
    endtask

    task automatic vid_op(input logic [13:0] adr, input bit keep);
        exp_t e;
        int   n;
        e.a = {2'b01, adr[12:0]}; e.d = ref_mem[e.a]; e.wr = 0; e.ub_n = 0; e.lb_n = 0;
        vid_q.push_back(e);
        vid_req = 1; vid_adr = adr;
        n = 0;
        do begin @(negedge m_clock); n++; end while (!vid_ack && n < 30);
        chk("vid_latency_ok", {31'b0, n <= 2 * (ACC + 1)}, 1);
        if (!keep) vid_req = 0;
    endtask

    function automatic logic [15:0] rand_word_adr(input int kind);
        logic [14:0] w;
        case (kind)
            0:       w = 15'h0100 + 15'($urandom_range(0, 15));
            1:       w = 15'h4100 + 15'($urandom_range(0, 15));
            default: w = 15'h2000 + 15'($urandom_range(0, 15));
        endcase
        return {w, 1'($urandom_range(0, 1))};
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[15'h0100] = 16'h1234; ref_mem[15'h0100] = 16'h1234;

        repeat (3) @(negedge m_clock);
        chk("rst_cpu_rdy", {31'b0, cpu_rdy}, 0);
        chk("rst_vid_ack", {31'b0, vid_ack}, 0);
        chk("rst_cpu_din", {16'b0, cpu_din}, 0);
        chk("rst_vid_data", {16'b0, vid_data}, 0);
        chk("rst_sram_a", {17'b0, sram_a}, 0);
        chk("rst_sram_d_o", {16'b0, sram_d_o}, 0);
        chk("rst_strobes", {27'b0, sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h0F);
        p_reset = 0;
        @(negedge m_clock);
        chk("idle_strobes", {27'b0, sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h0F);

        // Simultaneous requests straight after reset: video goes first.
        fork
            cpu_op(1, 0, 0, 16'h8024, 16'h0, 0);
            vid_op(14'h0000, 0);
        join
        chk("contention_gap", rdy_cyc - ack_cyc, ACC + 1);

        cpu_op(1, 0, 0, 16'o001000, 16'h0, 3);
        cpu_op(0, 1, 1, 16'o001001, 16'hABAB, 3);
        cpu_op(1, 0, 0, 16'o001000, 16'h0, 0);
        cpu_op(1, 1, 0, 16'h0210, 16'hC0DE, 1);
        cpu_op(1, 0, 0, 16'h0210, 16'h0, 0);

        // Reset in the middle of a write abandons it.
        cpu_wt = 1; cpu_byte = 0; cpu_adr = 16'h0300; cpu_dout = 16'h5555;
        n = 0;
        do begin @(negedge m_clock); n++; end while (sram_we_n && n < 10);
        chk("midwr_we_low_seen", {31'b0, sram_we_n}, 0);
        p_reset = 1;
        #1;
        chk("midwr_rst_we_n", {31'b0, sram_we_n}, 1);
        chk("midwr_rst_d_oe", {31'b0, sram_d_oe}, 0);
        chk("midwr_rst_rdy", {31'b0, cpu_rdy}, 0);
        chk("midwr_rst_din", {16'b0, cpu_din}, 0);
        repeat (2) @(negedge m_clock);
        cpu_wt = 0; p_reset = 0; exp_din = '0;
        @(negedge m_clock);
        cpu_op(1, 0, 0, 16'h0300, 16'h0, 0);

        // Random traffic: continuous-ish video against random CPU ops.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    int          kind;
                    logic [15:0] a;
                    logic [7:0]  b;
                    kind = int'($urandom_range(0, 3));
                    b = 8'($urandom);
                    if (kind == 0) cpu_op(1, 0, 1'($urandom), rand_word_adr(int'($urandom_range(0, 2))), 16'h0, int'($urandom_range(0, 2)));
                    else begin
                        a = rand_word_adr(int'($urandom_range(0, 1)));
                        if (kind == 1) cpu_op(0, 1, 0, a, 16'($urandom), int'($urandom_range(0, 2)));
                        else if (kind == 2) cpu_op(0, 1, 1, a, {b, b}, int'($urandom_range(0, 2)));
                        else cpu_op(1, 0, 0, a, 16'h0, 0);
                    end
                end
            end
            begin
                for (int j = 0; j < 90; j++) begin
                    bit keep;
                    keep = ($urandom_range(0, 3) != 0);
                    vid_op(14'($urandom) & 14'h200F, keep);
                    if (!keep) repeat ($urandom_range(0, 3)) @(negedge m_clock);
                end
                vid_req = 0;
            end
        join

        repeat (10) @(negedge m_clock);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("vid_q_drained", vid_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
